approx_wallace_mac_accumulator: RTL and testbench
=================================================

Name: approx_wallace_mac_accumulator

Overview:
Downstream consumer of the approximate 8-bit Wallace-tree multiplier (the output of its final reduction layer). Accepts a stream of 8-bit operand pairs over a valid/ready handshake, multiplies each pair, and accumulates the 16-bit products into a saturating accumulator. On the beat marked last, it presents the dot-product result on a valid/ready output port.

Parameters:
ACC_W, 24, accumulator and result width in bits (>=17).
CNT_W, 8, beat-counter width; counter saturates at 2^CNT_W-1.
USE_EXACT, 0, 1 = exact A*B product (verification mode); 0 = approximate Wallace-tree product.

Ports:
clk  input  1  single clock; all state on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  operand pair valid
in_ready  output  1  block can accept a pair this cycle
in_a  input  8  unsigned operand A
in_b  input  8  unsigned operand B
in_last  input  1  final pair of the current vector
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
out_acc  output  ACC_W  accumulated sum
out_count  output  CNT_W  number of pairs accumulated
out_sat  output  1  accumulator saturated during this vector

Behaviour:
- Reset is synchronous, active-high, one clock, single clock domain. On reset: state=IDLE, all pipeline valids=0, acc=0, count=0, sat=0, out_valid=0, out_acc=0, out_count=0, out_sat=0. Reset mid-vector discards all in-flight beats. No output is produced for a discarded vector.
- Input accept: a pair is accepted when in_valid && in_ready.
- Pipeline: the product is registered in stage P (1 cycle after accept). Stage P is added into acc on the next cycle. The output result appears 3 cycles after acceptance of the last beat (accept edge, P, acc update, out register).
- FSM states and transitions:
  - IDLE: in_ready=1. First accept -> ACCUM.
  - ACCUM: in_ready=1. Accepting in_last -> DRAIN.
  - DRAIN: in_ready=0. Waits until the last beat has updated acc, then loads out_* with out_valid=1 -> HOLD.
  - HOLD: in_ready=0. out_valid && out_ready -> IDLE, with acc/count/sat cleared in the same cycle.
- A single-beat vector (in_last on the first accept) goes IDLE -> DRAIN directly.
- in_valid=0 bubbles in IDLE/ACCUM are legal. Pipeline stages advance with valid bits, no stall needed, because in_ready never rises while results are pending.
- Arithmetic: product is 16-bit unsigned, zero-extended to ACC_W. If acc + product >= 2^ACC_W, acc is held at 2^ACC_W-1 and sat is set sticky until the vector is cleared.
- count increments per accumulated beat and saturates at 2^CNT_W-1. It does not wrap.
- out_acc, out_count and out_sat are stable while out_valid=1 and out_ready=0.
- in_last with in_valid=0 is ignored. in_a/in_b values are don't-care when not accepted.

Decomposition:
- Shared package approx_mac_pkg:
  - state enum {IDLE, ACCUM, DRAIN, HOLD}.
  - PROD_W=16 constant.
  - saturation helper function sat_add(acc, prod).
- Natural sub-module: approx_mac_product_stage.
  - Wraps the existing approximate 8-bit Wallace-tree multiplier top, or the exact A*B product when USE_EXACT=1.
  - Owns the stage-P register and its valid bit.

Test Plan:
- USE_EXACT=1, vector (3,4),(5,6),(7,8) with last on the third pair, out_ready=1 -> out_acc=98, out_count=3, out_sat=0, out_valid exactly 3 cycles after the last accept.
- Single beat (255,255,last), out_ready=0 for 5 cycles -> out_acc=65025 held stable, in_ready=0 throughout HOLD. out_ready=1 -> IDLE with in_ready=1 next cycle.
- ACC_W=17, USE_EXACT=1, pairs (255,255) x3 -> acc saturates at 131071, out_sat=1. The next vector (2,2,last) -> out_acc=4, out_sat=0.
- Bubbles: in_valid toggled 1,0,0,1(last) with pairs (10,10),(1,1) -> out_acc=101, out_count=2.
- Reset asserted for one cycle after 2 accepted beats of a vector -> no out_valid. Next vector (9,9,last) -> out_acc=81, out_count=1.
- USE_EXACT=0: 1000 random vectors -> out_acc equals a bit-accurate model of the approximate multiplier summed; out_count is correct in every vector.

Source files
------------

// File: rtl/approx_mac_pkg.sv
// Shared types, constants and the saturating-add helper for the approximate
// Wallace-tree multiply-accumulate block.
package approx_mac_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DRAIN,
    HOLD
  } state_e;

  localparam int unsigned OPND_W    = 8;
  localparam int unsigned PROD_W    = 16;
  localparam int unsigned MAX_ACC_W = 64;

  // Partial-product columns below this weight are dropped by the approximate tree.
  localparam int unsigned APPROX_TRUNC_COLS = 4;

  // Returns {overflow, clamped_sum}; the sum is clamped to 2^acc_w-1 (acc_w <= 63).
  function automatic logic [MAX_ACC_W:0] sat_add(
    input logic [MAX_ACC_W-1:0] acc,
    input logic [PROD_W-1:0]    prod,
    input int unsigned          acc_w
  );
    logic [MAX_ACC_W:0] sum;
    logic [MAX_ACC_W:0] lim;
    sum = {1'b0, acc} + {{(MAX_ACC_W + 1 - PROD_W){1'b0}}, prod};
    lim = (MAX_ACC_W + 1)'(1) << acc_w;
    if (sum >= lim) begin
      sat_add                = lim - (MAX_ACC_W + 1)'(1);
      sat_add[MAX_ACC_W]     = 1'b1;
    end else begin
      sat_add = sum;
    end
  endfunction

endpackage

// File: rtl/approx_wallace_mac_accumulator_product.sv
// Product stage P: approximate 8x8 Wallace-tree multiplier (or exact A*B)
// followed by the stage-P register and its valid bit.
module approx_mac_product_stage
  import approx_mac_pkg::*;
#(
  parameter int unsigned USE_EXACT = 0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  input  logic [OPND_W-1:0] a_i,
  input  logic [OPND_W-1:0] b_i,
  output logic              valid_o,
  output logic [PROD_W-1:0] prod_o
);

  logic [PROD_W-1:0] prod_c;
  logic [PROD_W-1:0] prod_q;
  logic              valid_q;

  if (USE_EXACT != 0) begin : g_exact
    assign prod_c = PROD_W'(a_i) * PROD_W'(b_i);
  end else begin : g_approx
    localparam logic [PROD_W-1:0] TRUNC_MASK = '1 << APPROX_TRUNC_COLS;

    // 3:2 carry-save compressor, returns {carry, sum}.
    function automatic logic [2*PROD_W-1:0] csa(
      input logic [PROD_W-1:0] x,
      input logic [PROD_W-1:0] y,
      input logic [PROD_W-1:0] z
    );
      logic [PROD_W-1:0] s;
      logic [PROD_W-1:0] c;
      s   = x ^ y ^ z;
      c   = ((x & y) | (x & z) | (y & z)) << 1;
      csa = {c, s};
    endfunction

    logic [PROD_W-1:0] pp [OPND_W];
    logic [PROD_W-1:0] s0, c0, s1, c1, s2, c2, s3, c3, s4, c4, s5, c5;

    // Reduction 8 -> 6 -> 4 -> 3 -> 2 rows, then a single carry-propagate add.
    always_comb begin
      for (int unsigned j = 0; j < OPND_W; j++) begin
        pp[j] = (PROD_W'(a_i & {OPND_W{b_i[j]}}) << j) & TRUNC_MASK;
      end
      {c0, s0} = csa(pp[0], pp[1], pp[2]);
      {c1, s1} = csa(pp[3], pp[4], pp[5]);
      {c2, s2} = csa(s0, c0, s1);
      {c3, s3} = csa(c1, pp[6], pp[7]);
      {c4, s4} = csa(s2, c2, s3);
      {c5, s5} = csa(s4, c4, c3);
      prod_c   = s5 + c5;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      prod_q  <= '0;
    end else begin
      valid_q <= valid_i;
      prod_q  <= prod_c;
    end
  end

  assign valid_o = valid_q;
  assign prod_o  = prod_q;

endmodule

// File: rtl/approx_wallace_mac_accumulator.sv
// Saturating dot-product accumulator over a valid/ready operand stream,
// result presented on a valid/ready output port after the last beat drains.
module approx_wallace_mac_accumulator
  import approx_mac_pkg::*;
#(
  parameter int unsigned ACC_W     = 24,
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned USE_EXACT = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic [CNT_W-1:0] out_count,
  output logic             out_sat
);

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               sat_q, sat_d;
  logic               out_valid_q, out_valid_d;
  logic [ACC_W-1:0]   out_acc_q, out_acc_d;
  logic [CNT_W-1:0]   out_cnt_q, out_cnt_d;
  logic               out_sat_q, out_sat_d;

  logic               accept;
  logic               p_valid;
  logic [PROD_W-1:0]  p_prod;
  logic [MAX_ACC_W:0] sa;
  logic               sat_hit;

  assign in_ready = (state_q == IDLE) || (state_q == ACCUM);
  assign accept   = in_valid && in_ready;

  approx_mac_product_stage #(
    .USE_EXACT (USE_EXACT)
  ) u_prod (
    .clk_i   (clk),
    .rst_i   (rst),
    .valid_i (accept),
    .a_i     (in_a),
    .b_i     (in_b),
    .valid_o (p_valid),
    .prod_o  (p_prod)
  );

  // Bits above ACC_W are always zero after clamping; folding them in keeps every bit used.
  assign sa      = sat_add({{(MAX_ACC_W - ACC_W){1'b0}}, acc_q}, p_prod, ACC_W);
  assign sat_hit = sa[MAX_ACC_W] | (|sa[MAX_ACC_W-1:ACC_W]);

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    sat_d       = sat_q;
    out_valid_d = out_valid_q;
    out_acc_d   = out_acc_q;
    out_cnt_d   = out_cnt_q;
    out_sat_d   = out_sat_q;

    if (p_valid) begin
      acc_d = sa[ACC_W-1:0];
      sat_d = sat_q | sat_hit;
      cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (accept) state_d = in_last ? DRAIN : ACCUM;
      end
      ACCUM: begin
        if (accept && in_last) state_d = DRAIN;
      end
      DRAIN: begin
        // Stage P empty means the last beat is already folded into acc_q.
        if (!p_valid) begin
          out_valid_d = 1'b1;
          out_acc_d   = acc_q;
          out_cnt_d   = cnt_q;
          out_sat_d   = sat_q;
          state_d     = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          acc_d       = '0;
          cnt_d       = '0;
          sat_d       = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      sat_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_acc_q   <= '0;
      out_cnt_q   <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      sat_q       <= sat_d;
      out_valid_q <= out_valid_d;
      out_acc_q   <= out_acc_d;
      out_cnt_q   <= out_cnt_d;
      out_sat_q   <= out_sat_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_acc   = out_acc_q;
  assign out_count = out_cnt_q;
  assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_approx_wallace_mac_accumulator.sv
// Drives an exact 17-bit instance and an approximate 24-bit instance with the
// same stream and compares both against a behavioural dot-product model.
module tb_approx_wallace_mac_accumulator;

  localparam int unsigned XW = 17;
  localparam int unsigned AW = 24;
  localparam int unsigned CW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [7:0]    in_a = '0;
  logic [7:0]    in_b = '0;
  logic          in_last = 1'b0;
  logic          out_ready = 1'b0;

  logic          in_ready_x, out_valid_x, out_sat_x;
  logic [XW-1:0] out_acc_x;
  logic [CW-1:0] out_count_x;
  logic          in_ready_a, out_valid_a, out_sat_a;
  logic [AW-1:0] out_acc_a;
  logic [CW-1:0] out_count_a;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] va[$];
  logic [7:0] vb[$];
  int         vg[$];

  always #5 clk = ~clk;

  approx_wallace_mac_accumulator #(
    .ACC_W     (XW),
    .CNT_W     (CW),
    .USE_EXACT (1)
  ) dut_x (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready_x),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_last   (in_last),
    .out_valid (out_valid_x),
    .out_ready (out_ready),
    .out_acc   (out_acc_x),
    .out_count (out_count_x),
    .out_sat   (out_sat_x)
  );

  approx_wallace_mac_accumulator #(
    .ACC_W     (AW),
    .CNT_W     (CW),
    .USE_EXACT (0)
  ) dut_a (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready_a),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_last   (in_last),
    .out_valid (out_valid_a),
    .out_ready (out_ready),
    .out_acc   (out_acc_a),
    .out_count (out_count_a),
    .out_sat   (out_sat_a)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Approximate product: sum of all partial-product bits of weight 2^4 and above.
  function automatic longint m_mul(input logic [7:0] a, input logic [7:0] b, input bit exact);
    longint p = 0;
    if (exact) return longint'(a) * longint'(b);
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        if (i + j >= 4 && a[i] && b[j]) p += longint'(1) << (i + j);
    return p;
  endfunction

  task automatic m_vec(input bit exact, input int w, output longint acc, output longint cnt,
                       output bit sat);
    longint lim = (longint'(1) << w) - 1;
    acc = 0;
    sat = 0;
    for (int k = 0; k < va.size(); k++) begin
      acc += m_mul(va[k], vb[k], exact);
      if (acc > lim) begin
        acc = lim;
        sat = 1;
      end
    end
    cnt = (va.size() > 255) ? 255 : va.size();
  endtask

  task automatic run_vec(input string tag, input int hold);
    longint xa, xc, aa, ac;
    bit     xs, as_;
    int     n;
    int     lat;
    n = va.size();
    m_vec(1'b1, XW, xa, xc, xs);
    m_vec(1'b0, AW, aa, ac, as_);
    for (int k = 0; k < n; k++) begin
      for (int g = 0; g < vg[k]; g++) begin
        @(negedge clk);
        in_valid = 1'b0;
        in_a     = 8'($urandom);
        in_b     = 8'($urandom);
        in_last  = 1'($urandom);
      end
      @(negedge clk);
      chk({tag, "_in_ready"}, 64'(in_ready_x), 64'd1);
      in_valid = 1'b1;
      in_a     = va[k];
      in_b     = vb[k];
      in_last  = (k == n - 1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    lat = 1;
    while (!out_valid_x && lat < 20) begin
      chk({tag, "_drain_ready"}, 64'(in_ready_x), 64'd0);
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, 64'(lat), 64'd3);
    chk({tag, "_valid_a"}, 64'(out_valid_a), 64'd1);
    chk({tag, "_acc_x"}, 64'(out_acc_x), 64'(xa));
    chk({tag, "_cnt_x"}, 64'(out_count_x), 64'(xc));
    chk({tag, "_sat_x"}, 64'(out_sat_x), 64'(xs));
    chk({tag, "_acc_a"}, 64'(out_acc_a), 64'(aa));
    chk({tag, "_cnt_a"}, 64'(out_count_a), 64'(ac));
    chk({tag, "_sat_a"}, 64'(out_sat_a), 64'(as_));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk({tag, "_hold_valid"}, 64'(out_valid_x), 64'd1);
      chk({tag, "_hold_acc"}, 64'(out_acc_x), 64'(xa));
      chk({tag, "_hold_acc_a"}, 64'(out_acc_a), 64'(aa));
      chk({tag, "_hold_ready"}, 64'(in_ready_x), 64'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_post_valid"}, 64'(out_valid_x), 64'd0);
    chk({tag, "_post_ready"}, 64'(in_ready_x), 64'd1);
    chk({tag, "_post_ready_a"}, 64'(in_ready_a), 64'd1);
    va.delete();
    vb.delete();
    vg.delete();
  endtask

  task automatic push(input logic [7:0] a, input logic [7:0] b, input int gap);
    va.push_back(a);
    vb.push_back(b);
    vg.push_back(gap);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready_x), 64'd1);
    chk("rst_out_valid", 64'(out_valid_x), 64'd0);
    chk("rst_out_acc", 64'(out_acc_x), 64'd0);
    chk("rst_out_count", 64'(out_count_x), 64'd0);
    chk("rst_out_sat", 64'(out_sat_x), 64'd0);
    chk("rst_out_valid_a", 64'(out_valid_a), 64'd0);

    push(8'd3, 8'd4, 0); push(8'd5, 8'd6, 0); push(8'd7, 8'd8, 0);
    run_vec("dot3", 0);
    @(negedge clk);

    push(8'd255, 8'd255, 0);
    run_vec("single", 5);

    push(8'd255, 8'd255, 0); push(8'd255, 8'd255, 0); push(8'd255, 8'd255, 0);
    run_vec("satur", 1);
    push(8'd2, 8'd2, 0);
    run_vec("after_sat", 0);

    push(8'd10, 8'd10, 0); push(8'd1, 8'd1, 2);
    run_vec("bubbles", 0);

    // Two beats accepted, then a one-cycle reset discards the vector.
    @(negedge clk);
    in_valid = 1'b1; in_a = 8'd50; in_b = 8'd60; in_last = 1'b0;
    @(negedge clk);
    in_a = 8'd70; in_b = 8'd80;
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("reset_no_out", 64'(out_valid_x | out_valid_a), 64'd0);
    end
    push(8'd9, 8'd9, 0);
    run_vec("post_reset", 0);

    for (int k = 0; k < 260; k++) push(8'($urandom), 8'($urandom), 0);
    run_vec("cnt_sat", 0);

    for (int v = 0; v < 1000; v++) begin
      int n = $urandom_range(1, 6);
      for (int k = 0; k < n; k++) push(8'($urandom), 8'($urandom), $urandom_range(0, 2));
      run_vec("rand", $urandom_range(0, 2));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
